// File: rtl/slicem_lutram_writer.sv
// Serializes whole-LUT memory images into the bit-serial SLICEM LUT-RAM write port.
// Images arrive over valid/ready. Each one goes MSB first to one LUT or to all LUTs at once.
module slicem_lutram_writer #(
  parameter int unsigned S_XX_BASE = 4,
  parameter int unsigned NUM_LUTS  = 4,
  parameter int unsigned MEM_BITS  = 2 * 2**S_XX_BASE,
  parameter int unsigned IDX_W     = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_lut,
  input  logic                req_bcast,
  input  logic [MEM_BITS-1:0] req_data,
  input  logic                stall,
  output logic                data_in,
  output logic                write_en,
  output logic [NUM_LUTS-1:0] write_lut_select,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // One extra bit so the counter can never wrap.
  localparam int unsigned CntW = $clog2(MEM_BITS) + 1;

  typedef enum logic [1:0] {StIdle, StShift, StDone, StErr} state_e;

  state_e              state_q, state_d;
  logic [MEM_BITS-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NUM_LUTS-1:0] sel_q, sel_d;

  logic accept;
  logic lut_bad;

  assign accept  = req_valid & req_ready;
  // The LUT index is only meaningful for targeted writes.
  assign lut_bad = !req_bcast && (32'(req_lut) >= NUM_LUTS);

  // Next-state logic for the FSM, the shift register, the counter and the select register.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shreg_d = req_data;
          cnt_d   = '0;
          sel_d   = req_bcast ? {NUM_LUTS{1'b1}} : (NUM_LUTS'(1) << req_lut);
          state_d = lut_bad ? StErr : StShift;
        end
      end
      StShift: begin
        if (!stall) begin
          shreg_d = {shreg_q[MEM_BITS-2:0], 1'b0};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == CntW'(MEM_BITS - 1)) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode: the write port is driven only while shifting.
  always_comb begin
    data_in          = 1'b0;
    write_en         = 1'b0;
    write_lut_select = '0;
    done             = 1'b0;
    err              = 1'b0;
    case (state_q)
      StShift: begin
        data_in          = shreg_q[MEM_BITS-1];
        write_en         = !stall;
        write_lut_select = sel_q;
      end
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: ;
    endcase
  end

  assign busy      = (state_q != StIdle);
  assign req_ready = rst_n & (state_q == StIdle);

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

endmodule

// File: tb/tb_slicem_lutram_writer.sv
// Self-checking bench for slicem_lutram_writer. It uses directed and randomized requests.
// A LUT memory model is fed from the serial write port.
module tb_slicem_lutram_writer;

  localparam int MEM_BITS = 32;
  localparam int NL       = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                req_valid, req_valid3;
  logic                req_ready, req_ready3;
  logic [1:0]          req_lut;
  logic                req_bcast;
  logic [MEM_BITS-1:0] req_data;
  logic                stall;
  logic                data_in, data_in3;
  logic                write_en, write_en3;
  logic [NL-1:0]       write_lut_select;
  logic [2:0]          write_lut_select3;
  logic                busy, busy3, done, done3, err, err3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slicem_lutram_writer #(.S_XX_BASE(4), .NUM_LUTS(4)) u_dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_lut          (req_lut),
    .req_bcast        (req_bcast),
    .req_data         (req_data),
    .stall            (stall),
    .data_in          (data_in),
    .write_en         (write_en),
    .write_lut_select (write_lut_select),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  slicem_lutram_writer #(.S_XX_BASE(4), .NUM_LUTS(3)) u_dut3 (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid3),
    .req_ready        (req_ready3),
    .req_lut          (req_lut),
    .req_bcast        (req_bcast),
    .req_data         (req_data),
    .stall            (stall),
    .data_in          (data_in3),
    .write_en         (write_en3),
    .write_lut_select (write_lut_select3),
    .busy             (busy3),
    .done             (done3),
    .err              (err3)
  );

  // LUT RAM model: the k-th strobe of an image writes memory bit MEM_BITS-1-k of each selected LUT.
  logic [MEM_BITS-1:0] mem [NL];
  int mctr    = 0;
  int strobes = 0;
  int dones   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      mctr <= 0;
    end else begin
      if (write_en) begin
        if (mctr < MEM_BITS) begin
          for (int l = 0; l < NL; l++) begin
            if (write_lut_select[l]) mem[l][MEM_BITS-1-mctr] <= data_in;
          end
        end
        mctr    <= mctr + 1;
        strobes <= strobes + 1;
      end
      if (done) begin
        mctr  <= 0;
        dones <= dones + 1;
      end
    end
  end

  logic [MEM_BITS-1:0] exp_mem [NL];
  logic [NL-1:0]       known = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one request, follow it through its write stream, and check done, ready and LUT contents.
  // smask bit k sets stall in the k-th cycle after acceptance. hold leaves req_valid high afterwards.
  task automatic run_req(input int lut, input bit bcast, input logic [MEM_BITS-1:0] data,
                         input logic [63:0] smask, input bit hold);
    int w, n, k;
    logic [NL-1:0] esel;
    req_lut   = 2'(lut);
    req_bcast = bcast;
    req_data  = data;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", req_ready, 1'b1);
    if (!req_ready) return;
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    esel = bcast ? 4'hF : (4'b0001 << lut);
    n = 0;
    k = 0;
    while (n < MEM_BITS && k < 200) begin
      stall = (k < 64) ? smask[k] : 1'b0;
      @(negedge clk);
      check("shift_sel", write_lut_select, esel);
      check("shift_we", write_en, !stall);
      check("shift_busy", busy, 1'b1);
      check("shift_ready", req_ready, 1'b0);
      check("shift_done", done, 1'b0);
      if (!stall) begin
        check("shift_din", data_in, data[MEM_BITS-1-n]);
        n++;
      end
      @(posedge clk);
      #1;
      k++;
    end
    stall = (k < 64) ? smask[k] : 1'b0;
    @(negedge clk);
    check("done_pulse", done, 1'b1);
    check("done_we", write_en, 1'b0);
    check("done_sel", write_lut_select, 4'h0);
    check("done_ready", req_ready, 1'b0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    @(negedge clk);
    check("post_ready", req_ready, 1'b1);
    check("post_done", done, 1'b0);
    check("post_busy", busy, 1'b0);
    for (int l = 0; l < NL; l++) begin
      if (esel[l]) begin
        exp_mem[l] = data;
        known[l]   = 1'b1;
      end
    end
    for (int l = 0; l < NL; l++) begin
      if (known[l]) check("lut_mem", mem[l], exp_mem[l]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [MEM_BITS-1:0] d;
    int s0, d0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_valid3 = 1'b0;
    req_lut    = '0;
    req_bcast  = 1'b0;
    req_data   = '0;
    stall      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 1'b0);
    check("rst_ready3", req_ready3, 1'b0);
    check("rst_we", write_en, 1'b0);
    check("rst_sel", write_lut_select, 4'h0);
    check("rst_din", data_in, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", req_ready, 1'b1);
    check("rel_ready3", req_ready3, 1'b1);

    // Targeted write, then broadcast with an ignored index, then the same targeted write with stalls.
    run_req(2, 1'b0, 32'hA5A5_0F0F, 64'h0, 1'b0);
    run_req(1, 1'b1, 32'hFFFF_0000, 64'h0, 1'b0);
    run_req(2, 1'b0, 32'hA5A5_0F0F, 64'h7C, 1'b0);

    // A bad index on the 3-LUT instance is rejected, and nothing is strobed.
    req_lut    = 2'd3;
    req_bcast  = 1'b0;
    req_valid3 = 1'b1;
    @(posedge clk);
    #1 req_valid3 = 1'b0;
    stall = 1'b1;
    @(negedge clk);
    check("err_pulse", err3, 1'b1);
    check("err_we", write_en3, 1'b0);
    check("err_sel", write_lut_select3, 3'h0);
    check("err_ready", req_ready3, 1'b0);
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    check("err_clear", err3, 1'b0);
    check("err_ready_back", req_ready3, 1'b1);
    check("err_no_we", write_en3, 1'b0);
    check("err_no_done", done3, 1'b0);

    // Reset while bit 10 of an image is being strobed.
    d0        = dones;
    d         = $urandom;
    req_lut   = 2'd1;
    req_bcast = 1'b0;
    req_data  = d;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 10) rst_n = 1'b0;
      @(negedge clk);
      check("rstmid_we", write_en, 1'b1);
      check("rstmid_din", data_in, d[MEM_BITS-1-i]);
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_we_off", write_en, 1'b0);
      check("rstmid_ready", req_ready, 1'b0);
      check("rstmid_done", done, 1'b0);
      check("rstmid_sel", write_lut_select, 4'h0);
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    known[1] = 1'b0;
    @(negedge clk);
    check("rstmid_ready_back", req_ready, 1'b1);
    check("rstmid_no_done", dones, d0);

    // Three back-to-back requests with req_valid held high throughout.
    s0 = strobes;
    d0 = dones;
    for (int i = 0; i < 3; i++) begin
      run_req($urandom_range(0, 3), 1'b0, $urandom, 64'h0, i < 2);
    end
    req_valid = 1'b0;
    check("b2b_strobes", strobes - s0, 96);
    check("b2b_dones", dones - d0, 3);

    // Randomized requests with random stall patterns and random holding.
    for (int i = 0; i < 10; i++) begin
      run_req($urandom_range(0, 3), ($urandom_range(0, 3) == 0), $urandom,
              {$urandom & $urandom, $urandom & $urandom}, $urandom_range(0, 1) == 1);
    end
    req_valid = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
